// File: rtl/wb_mac_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mac_bridge
//  Purpose  : Wishbone classic slave that exposes operand/control registers
//             for an attached arithmetic unit, issues a one-cycle launch
//             strobe, captures the unit's result on its valid strobe and
//             guards the wait with a timeout watchdog. Sticky status bits
//             drive a level interrupt.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    wb_clk_i, wb_rst_ni       clock, synchronous active-low reset
//    wbs_stb_i/cyc_i/we_i      Wishbone classic strobes
//    wbs_sel_i[3:0]            byte enables
//    wbs_adr_i[31:0]           byte address (bits [31:8] decoded)
//    wbs_dat_i[31:0]           write data
//    wbs_ack_o, wbs_dat_o      acknowledge, registered read data
//    op_a_o, op_b_o, op_c_o    operands latched at launch
//    op_rnd_o[1:0]             rounding mode latched at launch
//    op_valid_o                one-cycle launch strobe
//    res_valid_i, res_data_i   result strobe and data from the unit
//    irq_o                     level interrupt, DONE & IRQ_EN (registered)
// ============================================================================
module wb_mac_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] op_a_o,
  output logic [15:0] op_b_o,
  output logic [31:0] op_c_o,
  output logic [1:0]  op_rnd_o,
  output logic        op_valid_o,
  input  logic        res_valid_i,
  input  logic [31:0] res_data_i,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  ADR_OPA   = 8'h00;
  localparam logic [7:0]  ADR_OPB   = 8'h04;
  localparam logic [7:0]  ADR_OPC   = 8'h08;
  localparam logic [7:0]  ADR_CTRL  = 8'h0C;
  localparam logic [7:0]  ADR_STAT  = 8'h10;
  localparam logic [7:0]  ADR_RES   = 8'h14;
  localparam logic [7:0]  ADR_CYC   = 8'h18;

  state_e      state_q, state_d;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [15:0] opa_q, opb_q;
  logic [31:0] opc_q;
  logic [1:0]  rnd_q;
  logic        irq_en_q;
  logic        done_q, tout_q, ovr_q;
  logic [31:0] result_q;
  logic [15:0] cycles_q;
  logic [15:0] cnt_q;
  logic [15:0] op_a_q, op_b_q;
  logic [31:0] op_c_q;
  logic [1:0]  op_rnd_q;
  logic        irq_q;

  logic [7:0]  w_off;
  logic        w_hit, w_req, w_wr, w_rd, w_busy;
  logic        w_ctrl_wr, w_start, w_launch, w_overrun;
  logic        w_w1c, w_capture, w_timeout;
  logic [31:0] w_rdata;

  assign w_off  = wbs_adr_i[7:0];
  assign w_hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A request is accepted only when no ack is pending, so a held strobe
  // yields one ack every other cycle. Writes commit on the same edge that
  // raises the ack.
  assign w_req  = wbs_stb_i & wbs_cyc_i & w_hit & ~ack_q;
  assign w_wr   = w_req & wbs_we_i;
  assign w_rd   = w_req & ~wbs_we_i;
  assign w_busy = (state_q != ST_IDLE);

  assign w_ctrl_wr = w_wr & (w_off == ADR_CTRL) & wbs_sel_i[0];
  assign w_start   = w_ctrl_wr & wbs_dat_i[0];
  assign w_launch  = w_start & ~w_busy;
  assign w_overrun = w_start & w_busy;
  assign w_w1c     = w_wr & (w_off == ADR_STAT) & wbs_sel_i[0];

  // Result strobe wins over the watchdog when both land in the same cycle.
  assign w_capture = (state_q == ST_WAIT) & res_valid_i;
  assign w_timeout = (state_q == ST_WAIT) & ~res_valid_i & (cnt_q == CNT_LAST);

  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      ADR_OPA:  w_rdata = {16'h0, opa_q};
      ADR_OPB:  w_rdata = {16'h0, opb_q};
      ADR_OPC:  w_rdata = opc_q;
      ADR_CTRL: w_rdata = {28'h0, irq_en_q, rnd_q, 1'b0};
      ADR_STAT: w_rdata = {28'h0, ovr_q, tout_q, done_q, w_busy};
      ADR_RES:  w_rdata = result_q;
      ADR_CYC:  w_rdata = {16'h0, cycles_q};
      default:  w_rdata = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_launch) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (w_capture || w_timeout) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      opa_q    <= 16'h0;
      opb_q    <= 16'h0;
      opc_q    <= 32'h0;
      rnd_q    <= 2'b00;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      ovr_q    <= 1'b0;
      result_q <= 32'h0;
      cycles_q <= 16'h0;
      cnt_q    <= 16'h0;
      op_a_q   <= 16'h0;
      op_b_q   <= 16'h0;
      op_c_q   <= 32'h0;
      op_rnd_q <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      ack_q <= w_req;
      dat_q <= w_rd ? w_rdata : 32'h0;

      if (w_wr && (w_off == ADR_OPA)) begin
        if (wbs_sel_i[0]) opa_q[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) opa_q[15:8] <= wbs_dat_i[15:8];
      end
      if (w_wr && (w_off == ADR_OPB)) begin
        if (wbs_sel_i[0]) opb_q[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) opb_q[15:8] <= wbs_dat_i[15:8];
      end
      if (w_wr && (w_off == ADR_OPC)) begin
        for (int i = 0; i < 4; i++) begin
          if (wbs_sel_i[i]) opc_q[8*i +: 8] <= wbs_dat_i[8*i +: 8];
        end
      end
      if (w_ctrl_wr) begin
        rnd_q    <= wbs_dat_i[2:1];
        irq_en_q <= wbs_dat_i[3];
      end

      // The rounding mode is taken from the launching write itself so that
      // firmware can set RND and START with a single CTRL store.
      if (w_launch) begin
        op_a_q   <= opa_q;
        op_b_q   <= opb_q;
        op_c_q   <= opc_q;
        op_rnd_q <= wbs_dat_i[2:1];
        cnt_q    <= 16'h0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + 16'd1;
      end

      if (w_capture) begin
        result_q <= res_data_i;
        cycles_q <= cnt_q + 16'd1;
      end

      // Set conditions take precedence over write-1-to-clear.
      if (w_capture)                       done_q <= 1'b1;
      else if (w_launch)                   done_q <= 1'b0;
      else if (w_w1c && wbs_dat_i[1])      done_q <= 1'b0;

      if (w_timeout)                       tout_q <= 1'b1;
      else if (w_launch)                   tout_q <= 1'b0;
      else if (w_w1c && wbs_dat_i[2])      tout_q <= 1'b0;

      if (w_overrun)                       ovr_q  <= 1'b1;
      else if (w_w1c && wbs_dat_i[3])      ovr_q  <= 1'b0;

      irq_q <= done_q & irq_en_q;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign op_a_o     = op_a_q;
  assign op_b_o     = op_b_q;
  assign op_c_o     = op_c_q;
  assign op_rnd_o   = op_rnd_q;
  assign op_valid_o = (state_q == ST_LAUNCH);
  assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_mac_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_mac_bridge
//  Purpose  : Self-checking bench for wb_mac_bridge. A transaction-level
//             register model predicts read data and launch operands; a
//             monitor compares them whenever the DUT acks or launches.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_mac_bridge;

  localparam int          TOUT = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [15:0] op_a, op_b;
  logic [31:0] op_c;
  logic [1:0]  op_rnd;
  logic        op_valid;
  logic        res_valid;
  logic [31:0] res_data;
  logic        irq;

  wb_mac_bridge #(.BASE_ADDR(BASE), .TIMEOUT(TOUT)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_i),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .op_a_o     (op_a),
    .op_b_o     (op_b),
    .op_c_o     (op_c),
    .op_rnd_o   (op_rnd),
    .op_valid_o (op_valid),
    .res_valid_i(res_valid),
    .res_data_i (res_data),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rd;
    logic [31:0] exp;
    string       name;
  } bus_exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;
    logic [1:0]  r;
  } op_t;

  bus_exp_t bus_q[$];
  op_t      op_q[$];

  // Register model
  logic [15:0] m_opa, m_opb, m_cycles;
  logic [31:0] m_opc, m_result;
  logic [1:0]  m_rnd;
  logic        m_irqen, m_done, m_tout, m_ovr, m_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_opa = 16'h0; m_opb = 16'h0; m_opc = 32'h0; m_rnd = 2'b00; m_irqen = 1'b0;
    m_done = 1'b0; m_tout = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    m_result = 32'h0; m_cycles = 16'h0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      8'h00:   return {16'h0, m_opa};
      8'h04:   return {16'h0, m_opb};
      8'h08:   return m_opc;
      8'h0C:   return {28'h0, m_irqen, m_rnd, 1'b0};
      8'h10:   return {28'h0, m_ovr, m_tout, m_done, m_busy};
      8'h14:   return m_result;
      8'h18:   return {16'h0, m_cycles};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] off, input logic [31:0] d,
                             input logic [3:0] s, output logic launched);
    logic [31:0] t;
    op_t o;
    launched = 1'b0;
    case (off)
      8'h00: begin t = merge({16'h0, m_opa}, d, {2'b00, s[1:0]}); m_opa = t[15:0]; end
      8'h04: begin t = merge({16'h0, m_opb}, d, {2'b00, s[1:0]}); m_opb = t[15:0]; end
      8'h08: m_opc = merge(m_opc, d, s);
      8'h0C: if (s[0]) begin
        if (d[0]) begin
          if (m_busy) m_ovr = 1'b1;
          else begin
            o.a = m_opa; o.b = m_opb; o.c = m_opc; o.r = d[2:1];
            op_q.push_back(o);
            m_done = 1'b0; m_tout = 1'b0; m_busy = 1'b1;
            launched = 1'b1;
          end
        end
        m_rnd = d[2:1];
        m_irqen = d[3];
      end
      8'h10: if (s[0]) begin
        if (d[1]) m_done = 1'b0;
        if (d[2]) m_tout = 1'b0;
        if (d[3]) m_ovr  = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    logic got;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin got = 1'b1; break; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL ack_timeout adr=%h: got no ack, expected ack", a);
      bus_q.delete();
    end
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s,
                          output logic launched);
    bus_exp_t e;
    model_write(off, d, s, launched);
    e.rd = 1'b0; e.exp = 32'h0; e.name = "wr";
    bus_q.push_back(e);
    bus_cycle(1'b1, BASE | {24'h0, off}, d, s);
  endtask

  task automatic wb_read(input logic [7:0] off);
    bus_exp_t e;
    e.rd = 1'b1; e.exp = model_read(off); e.name = $sformatf("rd_%02h", off);
    bus_q.push_back(e);
    bus_cycle(1'b0, BASE | {24'h0, off}, 32'h0, 4'hF);
  endtask

  // Called right after the launching write returns (mid launch cycle).
  // The unit answers d cycles after op_valid; answers beyond the watchdog
  // window arrive after the bridge has given up and must be ignored.
  task automatic respond(input int d, input logic [31:0] data);
    repeat (d) @(negedge clk);
    res_valid = 1'b1; res_data = data;
    @(negedge clk);
    res_valid = 1'b0;
    if (d <= TOUT) begin
      m_done = 1'b1; m_result = data; m_cycles = 16'(d);
    end else begin
      m_tout = 1'b1;
    end
    m_busy = 1'b0;
  endtask

  task automatic check_irq();
    repeat (2) @(negedge clk);
    check("irq", {31'h0, irq}, {31'h0, m_done & m_irqen});
  endtask

  task automatic read_all();
    for (int o = 0; o <= 32'h1C; o += 4) wb_read(8'(o));
  endtask

  // Monitor: compares read data on every ack and operands on every launch.
  always @(negedge clk) begin : mon
    bus_exp_t e;
    op_t      o;
    if (rst_n === 1'b1) begin
      if (ack === 1'b1) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: got ack adr=%h, expected none", adr);
        end else begin
          e = bus_q.pop_front();
          if (e.rd) check(e.name, dat_o, e.exp);
        end
      end
      if (op_valid === 1'b1) begin
        if (op_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_op_valid: got pulse, expected none");
        end else begin
          o = op_q.pop_front();
          check("op_a", {16'h0, op_a}, {16'h0, o.a});
          check("op_b", {16'h0, op_b}, {16'h0, o.b});
          check("op_c", op_c, o.c);
          check("op_rnd", {30'h0, op_rnd}, {30'h0, o.r});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic l, l2;
    int   cnt;
    logic [31:0] c;
    logic [3:0]  s;

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_i = 32'h0; res_valid = 1'b0; res_data = 32'h0;
    model_reset();

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_op_a", {16'h0, op_a}, 32'h0);
    check("rst_op_b", {16'h0, op_b}, 32'h0);
    check("rst_op_c", op_c, 32'h0);
    check("rst_op_rnd", {30'h0, op_rnd}, 32'h0);
    check("rst_op_valid", {31'h0, op_valid}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    read_all();

    // Normal operation
    wb_write(8'h00, 32'h0000_3C00, 4'hF, l);
    wb_write(8'h04, 32'h0000_4000, 4'hF, l);
    wb_write(8'h08, 32'h3F80_0000, 4'hF, l);
    wb_write(8'h0C, 32'h0000_0009, 4'hF, l);
    respond(4, 32'h4040_0000);
    repeat (2) @(negedge clk);
    read_all();
    check_irq();
    wb_write(8'h10, 32'h0000_0002, 4'hF, l);
    @(negedge clk);
    check("irq_after_w1c", {31'h0, irq}, {31'h0, m_done & m_irqen});

    // Timeout, with a late strobe that must be ignored
    wb_write(8'h0C, 32'h0000_0001, 4'hF, l);
    respond(TOUT + 3, 32'hDEAD_0001);
    repeat (2) @(negedge clk);
    read_all();

    // Result on the last watchdog cycle
    wb_write(8'h0C, 32'h0000_000B, 4'hF, l);
    respond(TOUT, 32'h1357_9BDF);
    repeat (2) @(negedge clk);
    read_all();
    check_irq();

    // Overrun: second START while busy
    wb_write(8'h0C, 32'h0000_0001, 4'hF, l);
    fork
      respond(6, 32'h1234_5678);
      begin
        wb_write(8'h0C, 32'h0000_0001, 4'hF, l2);
        wb_read(8'h10);
      end
    join
    repeat (2) @(negedge clk);
    read_all();
    wb_write(8'h10, 32'h0000_0008, 4'hF, l);
    wb_read(8'h10);

    // W1C of DONE on the capture edge
    wb_write(8'h0C, 32'h0000_0001, 4'hF, l);
    fork
      respond(3, 32'hCAFE_F00D);
      begin
        repeat (2) @(negedge clk);
        wb_write(8'h10, 32'h0000_0002, 4'hF, l2);
      end
    join
    repeat (2) @(negedge clk);
    wb_read(8'h10);
    wb_read(8'h14);

    // START without sel[0]
    wb_write(8'h0C, 32'h0000_0001, 4'b0010, l);
    repeat (4) @(negedge clk);
    wb_read(8'h10);
    wb_read(8'h0C);

    // Decode miss
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h100; dat_i = 32'hA5A5_A5A5; sel = 4'hF;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack === 1'b1) cnt++;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("decode_miss_acks", 32'(cnt), 32'h0);
    read_all();

    // Randomized operations
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1, 0) == 1) wb_write(8'h00, $urandom, 4'($urandom_range(15, 0)), l);
      if ($urandom_range(1, 0) == 1) wb_write(8'h04, $urandom, 4'($urandom_range(15, 0)), l);
      if ($urandom_range(1, 0) == 1) wb_write(8'h08, $urandom, 4'($urandom_range(15, 0)), l);
      c = $urandom;
      if ($urandom_range(3, 0) != 0) c[0] = 1'b1;
      s = ($urandom_range(4, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'hF;
      wb_write(8'h0C, c, s, l);
      if (l) respond(int'($urandom_range(12, 1)), $urandom);
      repeat (2) @(negedge clk);
      if ($urandom_range(1, 0) == 1) wb_write(8'h10, $urandom, 4'($urandom_range(15, 0)), l);
      read_all();
      check_irq();
    end

    // Reset in the middle of an operation; a late result is ignored
    wb_write(8'h00, 32'h0000_BEEF, 4'hF, l);
    wb_write(8'h0C, 32'h0000_0009, 4'hF, l);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    res_valid = 1'b1; res_data = 32'h7777_7777;
    @(negedge clk);
    res_valid = 1'b0;
    check("midrst_op_a", {16'h0, op_a}, 32'h0);
    read_all();
    check_irq();

    repeat (4) @(negedge clk);
    check("bus_q_empty", 32'(bus_q.size()), 32'h0);
    check("op_q_empty", 32'(op_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
